ex_alu_unit: RTL and testbench

EX_ALU_UNIT -- requirements
Module: ex_alu_unit

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_mul_iter.sv | 54 +++++
 rtl/ex_alu_unit.sv | 175 +++++++++++++++++
 tb/tb_ex_alu_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the execute-unit state encoding.
// Also consumed by the ALU control stage that produces ALUCtl.
package alu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  localparam int unsigned MUL_CNT_W = 5;

  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_ADDU = 6'b010011;
  localparam logic [5:0] OP_SUB  = 6'b000110;
  localparam logic [5:0] OP_AND  = 6'b000000;
  localparam logic [5:0] OP_OR   = 6'b000001;
  localparam logic [5:0] OP_XOR  = 6'b001101;
  localparam logic [5:0] OP_NOR  = 6'b001110;
  localparam logic [5:0] OP_SLT  = 6'b000111;
  localparam logic [5:0] OP_SLTU = 6'b010100;
  localparam logic [5:0] OP_SLL  = 6'b001000;
  localparam logic [5:0] OP_SRL  = 6'b001001;
  localparam logic [5:0] OP_SRA  = 6'b001011;
  localparam logic [5:0] OP_SLLV = 6'b010000;
  localparam logic [5:0] OP_SRLV = 6'b010001;
  localparam logic [5:0] OP_SRAV = 6'b010010;
  localparam logic [5:0] OP_CLO  = 6'b000100;
  localparam logic [5:0] OP_CLZ  = 6'b000101;
  localparam logic [5:0] OP_LUI  = 6'b100110;
  localparam logic [5:0] OP_MUL  = 6'b000011;
  localparam logic [5:0] OP_MOVN = 6'b001111;
  localparam logic [5:0] OP_MOVZ = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b100010;
  localparam logic [5:0] OP_BNE  = 6'b100011;
  localparam logic [5:0] OP_BLEZ = 6'b100100;
  localparam logic [5:0] OP_BGTZ = 6'b100101;
  localparam logic [5:0] OP_JR   = 6'b100000;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits kept.
// done/product are combinational on the final iteration so the caller registers them on that edge.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam logic [MUL_CNT_W-1:0] LAST = MUL_CNT_W'(WIDTH - 1);

  logic                 run;
  logic [MUL_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     acc;

  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (abort) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (run) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: registered single-cycle ops, branch/move gating, and an
// iterative multiplier that stalls the pipeline via Busy.
module ex_alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [5:0]       ALUCtl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Shamt,
  input  logic             Flush,
  output logic             OutValid,
  output logic [WIDTH-1:0] Result,
  output logic             WriteEn,
  output logic             BranchTaken,
  output logic             Busy
);

  state_t state;
  state_t state_nx;

  logic                         rdy;
  logic                         accept;
  logic                         is_mul;
  logic                         mul_start;
  logic                         mul_done;
  logic [WIDTH-1:0]             mul_prod;
  logic [WIDTH-1:0]             alu_res;
  logic                         alu_we;
  logic                         alu_br;
  logic [WIDTH-1:0]             lead_src;
  logic [$clog2(WIDTH+1)-1:0]   lead_cnt;
  logic                         lead_stop;

  // rdy keeps InReady low while reset is held and until the first clock after release
  assign InReady   = rdy && (state == IDLE);
  assign Busy      = (state == MUL);
  assign accept    = InValid && InReady && !Flush;
  assign is_mul    = (ALUCtl == OP_MUL);
  assign mul_start = accept && is_mul;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .start   (mul_start),
    .abort   (Flush),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_prod)
  );

  // clo reuses the zero counter on the inverted operand
  always_comb begin
    lead_src  = (ALUCtl == OP_CLO) ? ~A : A;
    lead_cnt  = '0;
    lead_stop = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!lead_stop && !lead_src[WIDTH-1-i]) lead_cnt = lead_cnt + 1'b1;
      else lead_stop = 1'b1;
    end
  end

  always_comb begin
    alu_res = '0;
    alu_we  = 1'b1;
    alu_br  = 1'b0;
    case (ALUCtl)
      OP_ADD, OP_ADDU: alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_SLT:  alu_res = WIDTH'($signed(A) < $signed(B));
      OP_SLTU: alu_res = WIDTH'(A < B);
      OP_SLL:  alu_res = B << Shamt;
      OP_SRL:  alu_res = B >> Shamt;
      OP_SRA:  alu_res = $signed(B) >>> Shamt;
      OP_SLLV: alu_res = B << A[4:0];
      OP_SRLV: alu_res = B >> A[4:0];
      OP_SRAV: alu_res = $signed(B) >>> A[4:0];
      OP_CLO, OP_CLZ: alu_res = WIDTH'(lead_cnt);
      OP_LUI:  alu_res = B << 16;
      OP_MUL:  alu_res = '0;
      OP_MOVN: begin
        alu_res = A;
        alu_we  = (B != '0);
      end
      OP_MOVZ: begin
        alu_res = A;
        alu_we  = (B == '0);
      end
      OP_BEQ: begin
        alu_res = A - B;
        alu_we  = 1'b0;
        alu_br  = (A == B);
      end
      OP_BNE: begin
        alu_res = A - B;
        alu_we  = 1'b0;
        alu_br  = (A != B);
      end
      OP_BLEZ: begin
        alu_res = A - B;
        alu_we  = 1'b0;
        alu_br  = A[WIDTH-1] || (A == '0);
      end
      OP_BGTZ: begin
        alu_res = A - B;
        alu_we  = 1'b0;
        alu_br  = !A[WIDTH-1] && (A != '0);
      end
      OP_JR: begin
        alu_res = A;
        alu_we  = 1'b0;
        alu_br  = 1'b1;
      end
      default: alu_we = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    if (Flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (mul_start) state_nx = MUL;
        MUL:     if (mul_done) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      rdy   <= 1'b0;
    end else begin
      state <= state_nx;
      rdy   <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      OutValid    <= 1'b0;
      Result      <= '0;
      WriteEn     <= 1'b0;
      BranchTaken <= 1'b0;
    end else begin
      OutValid <= 1'b0;
      if (!Flush) begin
        if (accept && !is_mul) begin
          OutValid    <= 1'b1;
          Result      <= alu_res;
          WriteEn     <= alu_we;
          BranchTaken <= alu_br;
        end else if (Busy && mul_done) begin
          OutValid    <= 1'b1;
          Result      <= mul_prod;
          WriteEn     <= 1'b1;
          BranchTaken <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Randomized bench for ex_alu_unit against an arithmetic reference model,
// plus directed flush, reset and boundary cases.
module tb_ex_alu_unit;

  logic        Clk;
  logic        Rst_n;
  logic        InValid;
  logic        InReady;
  logic [5:0]  ALUCtl;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  Shamt;
  logic        Flush;
  logic        OutValid;
  logic [31:0] Result;
  logic        WriteEn;
  logic        BranchTaken;
  logic        Busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        we;
    logic        br;
  } exp_t;

  localparam logic [5:0] MULOP = 6'b000011;
  logic [5:0] known_ops [26] = '{
    6'b000010, 6'b010011, 6'b000110, 6'b000000, 6'b000001, 6'b001101, 6'b001110,
    6'b000111, 6'b010100, 6'b001000, 6'b001001, 6'b001011, 6'b010000, 6'b010001,
    6'b010010, 6'b000100, 6'b000101, 6'b100110, 6'b000011, 6'b001111, 6'b001010,
    6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100000
  };

  ex_alu_unit #(.WIDTH(32)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .InValid     (InValid),
    .InReady     (InReady),
    .ALUCtl      (ALUCtl),
    .A           (A),
    .B           (B),
    .Shamt       (Shamt),
    .Flush       (Flush),
    .OutValid    (OutValid),
    .Result      (Result),
    .WriteEn     (WriteEn),
    .BranchTaken (BranchTaken),
    .Busy        (Busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lead_zeros(input logic [31:0] x);
    int n = 0;
    while (n < 32 && x[31-n] == 1'b0) n++;
    return n;
  endfunction

  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh);
    exp_t e;
    int   sa = a;
    int   sb = b;
    e.res = 32'h0;
    e.we  = 1'b1;
    e.br  = 1'b0;
    case (op)
      6'b000010, 6'b010011: e.res = a + b;
      6'b000110: e.res = a - b;
      6'b000000: e.res = a & b;
      6'b000001: e.res = a | b;
      6'b001101: e.res = a ^ b;
      6'b001110: e.res = ~(a | b);
      6'b000111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      6'b010100: e.res = (a < b) ? 32'd1 : 32'd0;
      6'b001000: e.res = b << sh;
      6'b001001: e.res = b >> sh;
      6'b001011: e.res = 32'(sb >>> sh);
      6'b010000: e.res = b << a[4:0];
      6'b010001: e.res = b >> a[4:0];
      6'b010010: e.res = 32'(sb >>> a[4:0]);
      6'b000100: e.res = 32'(lead_zeros(~a));
      6'b000101: e.res = 32'(lead_zeros(a));
      6'b100110: e.res = b * 32'd65536;
      6'b000011: e.res = a * b;
      6'b001111: begin e.res = a; e.we = (b != 0); end
      6'b001010: begin e.res = a; e.we = (b == 0); end
      6'b100010: begin e.res = a - b; e.we = 1'b0; e.br = (a == b); end
      6'b100011: begin e.res = a - b; e.we = 1'b0; e.br = (a != b); end
      6'b100100: begin e.res = a - b; e.we = 1'b0; e.br = (sa <= 0); end
      6'b100101: begin e.res = a - b; e.we = 1'b0; e.br = (sa > 0); end
      6'b100000: begin e.res = a; e.we = 1'b0; e.br = 1'b1; end
      default:   begin e.res = 32'h0; e.we = 1'b0; end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    exp_t e = model(op, a, b, sh);
    @(negedge Clk);
    InValid = 1'b1; ALUCtl = op; A = a; B = b; Shamt = sh;
    @(posedge Clk); #1;
    InValid = 1'b0;
    if (op == MULOP) begin
      for (int k = 0; k < 32; k++) begin
        check("mul_busy", 32'(Busy), 1);
        check("mul_inready", 32'(InReady), 0);
        check("mul_ov", 32'(OutValid), 0);
        A = $urandom; B = $urandom; ALUCtl = 6'($urandom); InValid = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
      end
      check("mul_busy_end", 32'(Busy), 0);
    end
    check("ov", 32'(OutValid), 1);
    check("res", Result, e.res);
    check("we", 32'(WriteEn), 32'(e.we));
    check("br", 32'(BranchTaken), 32'(e.br));
    check("ready", 32'(InReady), 1);
    @(posedge Clk); #1;
    check("ov_pulse", 32'(OutValid), 0);
    check("res_hold", Result, e.res);
    check("we_hold", 32'(WriteEn), 32'(e.we));
    check("br_hold", 32'(BranchTaken), 32'(e.br));
  endtask

  task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    InValid = 1'b1; ALUCtl = MULOP; A = a; B = b;
    @(posedge Clk); #1;
    InValid = 1'b0;
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge Clk); #1;
      if (OutValid) n++;
    end
  endtask

  initial begin
    int   n;
    logic [5:0] op;
    Rst_n = 1'b0; InValid = 1'b0; ALUCtl = '0; A = '0; B = '0; Shamt = '0; Flush = 1'b0;
    #2;
    check("rst_ov", 32'(OutValid), 0);
    check("rst_res", Result, 0);
    check("rst_we", 32'(WriteEn), 0);
    check("rst_br", 32'(BranchTaken), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_inready", 32'(InReady), 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    check("inready_before_edge", 32'(InReady), 0);
    @(posedge Clk); #1;
    check("inready_after_rst", 32'(InReady), 1);

    run_op(6'b000010, 32'h7FFF_FFFF, 32'h1, 5'd0);
    run_op(MULOP, 32'hFFFF_FFFF, 32'h3, 5'd0);
    run_op(6'b000101, 32'h0, 32'h0, 5'd0);
    run_op(6'b000100, 32'hF000_0000, 32'h0, 5'd0);
    run_op(6'b000100, 32'hFFFF_FFFF, 32'h0, 5'd0);
    run_op(6'b001010, 32'h5, 32'h0, 5'd0);
    run_op(6'b001111, 32'h5, 32'h0, 5'd0);
    run_op(6'b100100, 32'h8000_0000, 32'h0, 5'd0);
    run_op(6'b100101, 32'h0, 32'h0, 5'd0);
    run_op(6'b111111, 32'h1234, 32'h5678, 5'd3);
    run_op(6'b001011, 32'h0, 32'h8000_00F0, 5'd31);

    // flush mid-multiply
    run_op(6'b000001, 32'hA5A5_0000, 32'h0000_5A5A, 5'd0);
    start_mul(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge Clk);
    @(negedge Clk); Flush = 1'b1;
    @(posedge Clk); #1; Flush = 1'b0;
    check("flush_ov", 32'(OutValid), 0);
    check("flush_busy", 32'(Busy), 0);
    check("flush_inready", 32'(InReady), 1);
    count_pulses(40, n);
    check("flush_no_ov", 32'(n), 0);
    check("flush_res_hold", Result, 32'hA5A5_5A5A);

    // flush alongside a presented operation
    @(negedge Clk);
    InValid = 1'b1; ALUCtl = 6'b000010; A = 32'h1; B = 32'h1; Flush = 1'b1;
    @(posedge Clk); #1; InValid = 1'b0; Flush = 1'b0;
    check("flush_drop_ov", 32'(OutValid), 0);
    check("flush_drop_res", Result, 32'hA5A5_5A5A);
    run_op(6'b000110, 32'h0, 32'h1, 5'd0);

    // asynchronous reset mid-multiply
    run_op(6'b100000, 32'hDEAD_BEEF, 32'h0, 5'd0);
    start_mul(32'h7, 32'h9);
    repeat (5) @(posedge Clk);
    #3 Rst_n = 1'b0;
    #1;
    check("arst_ov", 32'(OutValid), 0);
    check("arst_res", Result, 0);
    check("arst_we", 32'(WriteEn), 0);
    check("arst_br", 32'(BranchTaken), 0);
    check("arst_busy", 32'(Busy), 0);
    check("arst_inready", 32'(InReady), 0);
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;
    check("arst_ready", 32'(InReady), 1);
    count_pulses(40, n);
    check("arst_no_ov", 32'(n), 0);

    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 15) == 0) op = 6'($urandom);
      else op = known_ops[$urandom_range(0, 25)];
      run_op(op, pick_operand(), pick_operand(), 5'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
